// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the oversampling UART receiver: the receiver FSM
// state type and the oversampling constants that fix where each bit is
// sampled within its 16-tick period.
// ---------------------------------------------------------------------------
package uart_pkg;

   localparam int OVERSAMPLE  = 16;                  // ticks per bit period
   localparam int MID_SAMPLE  = 7;                   // start-bit validation tick
   localparam int LAST_SAMPLE = 15;                  // data/parity/stop sample tick
   localparam int CNT_W       = $clog2(OVERSAMPLE);  // tick counter width

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// ---------------------------------------------------------------------------
// uart_rx_sync
// Front end of the UART receiver. It brings the asynchronous serial line into
// the clk domain with a two-flop synchronizer and flags its falling edges. It
// also turns the 16x baud square wave into single-cycle ticks.
//
// Ports
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   rx_i         in   raw serial line, idle high
//   baud_clk16_i in   16x baud square wave
//   rx_s_o       out  synchronized serial line
//   rx_fall_o    out  rx_s_o went 1 -> 0 this cycle
//   tick_o       out  one-cycle pulse on each baud_clk16_i rising edge
// ---------------------------------------------------------------------------
module uart_rx_sync
   import uart_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic rx_i,
   input  logic baud_clk16_i,
   output logic rx_s_o,
   output logic rx_fall_o,
   output logic tick_o
);

   logic rx_meta_q;
   logic rx_s_q;
   logic rx_prev_q;
   logic baud_q;

   // The synchronizer resets to the idle (high) line level. A reset therefore
   // never creates a false start edge.
   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // the pre-edge value of its neighbour; blocking here would collapse the
   // two-flop chain into one.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         rx_prev_q <= 1'b1;
         baud_q    <= 1'b0;
      end else begin
         rx_meta_q <= rx_i;
         rx_s_q    <= rx_meta_q;
         rx_prev_q <= rx_s_q;
         baud_q    <= baud_clk16_i;
      end
   end

   assign rx_s_o    = rx_s_q;
   assign rx_fall_o = rx_prev_q & ~rx_s_q;
   assign tick_o    = baud_clk16_i & ~baud_q;

endmodule

// File: rtl/uart_rx16.sv
// ---------------------------------------------------------------------------
// uart_rx16
// A 16x oversampling UART receiver. It validates the start bit at mid-bit and
// then samples each data bit, the optional parity bit and the stop bit once
// per bit period. Each completed frame goes into a one-entry valid/ready
// output buffer. When the buffer is still full, the new frame is dropped and
// overrun pulses.
//
// Build option
//   UART_RX_PARITY_EN  defined: one parity bit follows the data bits and is
//                      checked. Undefined: no parity bit, parity_err is 0.
//
// Parameters
//   DATA_BITS   data bits per frame, LSB first (5..9)
//   PARITY_ODD  0 = even parity, 1 = odd parity (parity builds only)
//
// Ports
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   baud_clk16  in   16x baud square wave
//   rx          in   serial line, idle high, asynchronous
//   rx_data     out  received word
//   rx_valid    out  rx_data and the error flags hold a frame
//   rx_ready    in   consumer accepts when rx_valid && rx_ready
//   frame_err   out  stop bit sampled low (qualified by rx_valid)
//   parity_err  out  parity mismatch (qualified by rx_valid)
//   overrun     out  one-cycle pulse: a completed frame was dropped
// ---------------------------------------------------------------------------
module uart_rx16
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 baud_clk16,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun
);

   localparam logic           PARITY_ODD_BIT = (PARITY_ODD != 0);
   localparam logic [3:0]     LAST_BIT_IDX   = 4'(DATA_BITS - 1);
   localparam logic [CNT_W-1:0] CNT_MID      = CNT_W'(MID_SAMPLE);
   localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(LAST_SAMPLE);

   // ------------------------------------------------------------------
   // Front end: synchronized line, start edge and baud ticks
   // ------------------------------------------------------------------
   logic rx_s;
   logic rx_fall;
   logic tick;

   uart_rx_sync u_sync (
      .clk          (clk),
      .reset_n      (reset_n),
      .rx_i         (rx),
      .baud_clk16_i (baud_clk16),
      .rx_s_o       (rx_s),
      .rx_fall_o    (rx_fall),
      .tick_o       (tick)
   );

   // ------------------------------------------------------------------
   // Receiver FSM
   // ------------------------------------------------------------------
   uart_rx_state_t       state_q,   state_d;
   logic [CNT_W-1:0]     cnt_q,     cnt_d;
   logic [3:0]           bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] shift_q,   shift_d;
`ifdef UART_RX_PARITY_EN
   logic                 parity_bit_q, parity_bit_d;
`endif

   logic frame_done;  // stop bit sampled this cycle
   logic stop_err;    // that stop bit was low
   logic parity_calc; // parity verdict for the frame being completed

   // NOTE: every signal assigned below gets a default first. No path can
   // leave one unassigned, so no latch is inferred.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
`ifdef UART_RX_PARITY_EN
      parity_bit_d = parity_bit_q;
`endif
      frame_done   = 1'b0;
      stop_err     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            // Only a 1->0 transition starts a frame. A line held low (break)
            // cannot retrigger.
            if (rx_fall) begin
               state_d = ST_START;
               cnt_d   = '0;
            end
         end

         ST_START: begin
            if (tick) begin
               if (cnt_q == CNT_MID) begin
                  if (!rx_s) begin
                     // From here the counter wraps every 16 ticks. Each
                     // LAST_SAMPLE tick then lands mid-bit.
                     state_d   = ST_DATA;
                     cnt_d     = '0;
                     bit_idx_d = '0;
                  end else begin
                     state_d = ST_IDLE;  // glitch, not a start bit
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         ST_DATA: begin
            if (tick) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  // LSB arrives first, so shifting in at the MSB leaves the
                  // word correctly aligned after DATA_BITS samples.
                  shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                  bit_idx_d = bit_idx_q + 1'b1;
                  if (bit_idx_q == LAST_BIT_IDX) begin
`ifdef UART_RX_PARITY_EN
                     state_d = ST_PARITY;
`else
                     state_d = ST_STOP;
`endif
                  end
               end
            end
         end

`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (tick) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  parity_bit_d = rx_s;
                  state_d      = ST_STOP;
               end
            end
         end
`endif

         ST_STOP: begin
            if (tick) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  // Return to IDLE at mid stop bit. The receiver then has
                  // half a bit of slack to see the next start edge.
                  frame_done = 1'b1;
                  stop_err   = ~rx_s;
                  state_d    = ST_IDLE;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: the shift register and counters are reset along with the state,
   // even though IDLE never reads them. This keeps the post-reset contents
   // deterministic and makes a mid-frame reset discard the partial word.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
`ifdef UART_RX_PARITY_EN
         parity_bit_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
`ifdef UART_RX_PARITY_EN
         parity_bit_q <= parity_bit_d;
`endif
      end
   end

`ifdef UART_RX_PARITY_EN
   // Nonzero means the data plus parity bit do not have the configured parity.
   assign parity_calc = (^shift_q) ^ parity_bit_q ^ PARITY_ODD_BIT;
`else
   assign parity_calc = 1'b0;
   logic unused_parity_odd;
   assign unused_parity_odd = PARITY_ODD_BIT;
`endif

   // ------------------------------------------------------------------
   // One-entry output buffer
   // ------------------------------------------------------------------
   logic [DATA_BITS-1:0] rx_data_q;
   logic                 rx_valid_q;
   logic                 frame_err_q;
   logic                 parity_err_q;
   logic                 overrun_q;

   logic accept;
   logic can_load;

   assign accept   = rx_valid_q & rx_ready;
   // The slot is free when it is empty or is being drained this very cycle.
   assign can_load = ~rx_valid_q | rx_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         overrun_q <= 1'b0;
         if (frame_done && can_load) begin
            rx_data_q    <= shift_q;
            frame_err_q  <= stop_err;
            parity_err_q <= parity_calc;
            rx_valid_q   <= 1'b1;
         end else begin
            // A full, unaccepted buffer keeps its frame; the new one is lost.
            if (frame_done) begin
               overrun_q <= 1'b1;
            end
            if (accept) begin
               rx_valid_q <= 1'b0;
            end
         end
      end
   end

   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign frame_err  = frame_err_q;
   assign parity_err = parity_err_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx16.sv
// ---------------------------------------------------------------------------
// tb_uart_rx16
// Self-checking bench for uart_rx16. It drives serial frames bit by bit and
// predicts every output from the frame contents: the data byte, the stop bit
// level and the parity of data plus parity bit.
// ---------------------------------------------------------------------------
module tb_uart_rx16;

   localparam int DATA_BITS  = 8;
   localparam int PARITY_ODD = 0;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   typedef struct packed {
      logic [7:0] data;
      logic       fe;
      logic       pe;
   } frame_t;

   logic       clk        = 1'b0;
   logic       reset_n    = 1'b1;
   logic       baud_clk16 = 1'b0;
   logic       rx         = 1'b1;
   logic       rx_ready   = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       parity_err;
   logic       overrun;

   int errors = 0;
   int checks = 0;
   int overrun_cnt = 0;
   int baud_half = 270;  // 50 MHz clk / 27 ~= 16 x 115200
   frame_t got_q[$];
   frame_t exp_q[$];

   uart_rx16 #(.DATA_BITS(DATA_BITS), .PARITY_ODD(PARITY_ODD)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .baud_clk16 (baud_clk16),
      .rx         (rx),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .overrun    (overrun)
   );

   always #10 clk = ~clk;

   // Baud edges sit at 3 mod 10 time units, never on a clk edge.
   initial begin
      #3;
      forever begin
         #(baud_half) baud_clk16 = ~baud_clk16;
      end
   end

   // Observe the overrun pulses and the accepted frames mid-cycle.
   always @(negedge clk) begin
      if (overrun === 1'b1) overrun_cnt++;
      if (rx_valid === 1'b1 && rx_ready === 1'b1)
         got_q.push_back(frame_t'{data: rx_data, fe: frame_err, pe: parity_err});
   end

   initial begin
      #4000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic good_par(input logic [7:0] d);
      return (^d) ^ (PARITY_ODD != 0);
   endfunction

   function automatic frame_t model(input logic [7:0] d, input logic stop_bit, input logic pbit);
      frame_t f;
      f.data = d;
      f.fe   = ~stop_bit;
      f.pe   = PAR_EN ? ((^d) ^ pbit ^ (PARITY_ODD != 0)) : 1'b0;
      return f;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic b);
      rx = b;
      #(32 * baud_half);
   endtask

   // Leaves the line at the stop-bit level.
   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic pbit);
      drive_bit(1'b0);
      for (int i = 0; i < DATA_BITS; i++) drive_bit(d[i]);
      if (PAR_EN) drive_bit(pbit);
      drive_bit(stop_bit);
   endtask

   task automatic pulse_ready();
      rx_ready = 1'b1;
      wait_clks(1);
      rx_ready = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #5 reset_n = 1'b0;
      wait_clks(3);
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", rx_data); end
      checks++; if ({frame_err, parity_err, overrun} !== 3'b000) begin errors++;
         $display("FAIL reset_flags: got %b expected 000", {frame_err, parity_err, overrun}); end
      reset_n = 1'b1;
      wait_clks(50);
   endtask

   task automatic test_clean_frame();
      frame_t e = model(8'hA5, 1'b1, good_par(8'hA5));
      rx_ready = 1'b0;
      send_frame(8'hA5, 1'b1, good_par(8'hA5));
      wait_clks(3);
      checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL clean_valid: got %b expected 1", rx_valid); end
      checks++; if ({rx_data, frame_err, parity_err} !== e) begin errors++;
         $display("FAIL clean_frame: got %h/%b/%b expected %h/%b/%b", rx_data, frame_err, parity_err, e.data, e.fe, e.pe); end
      wait_clks(200);
      checks++; if ({rx_valid, rx_data} !== {1'b1, 8'hA5}) begin errors++;
         $display("FAIL clean_hold: got %b/%h expected 1/a5", rx_valid, rx_data); end
      pulse_ready();
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL clean_accept: got %b expected 0", rx_valid); end
      baud_half = 40;  // faster ticks for the rest of the run
      wait_clks(20);
   endtask

   task automatic test_glitch();
      int ov0 = overrun_cnt;
      rx = 1'b0;
      #(4 * 2 * baud_half);
      rx = 1'b1;
      wait_clks(160);
      checks++; if (rx_valid !== 1'b0 || overrun_cnt != ov0) begin errors++;
         $display("FAIL glitch_no_frame: got valid=%b overruns=%0d expected 0/0", rx_valid, overrun_cnt - ov0); end
      send_frame(8'h3C, 1'b1, good_par(8'h3C));
      wait_clks(3);
      checks++; if ({rx_valid, rx_data, frame_err} !== {1'b1, 8'h3C, 1'b0}) begin errors++;
         $display("FAIL glitch_next: got %b/%h/%b expected 1/3c/0", rx_valid, rx_data, frame_err); end
      pulse_ready();
   endtask

   task automatic test_framing();
      send_frame(8'h3C, 1'b0, good_par(8'h3C));  // line stays low afterwards
      wait_clks(3);
      checks++; if ({rx_valid, rx_data, frame_err} !== {1'b1, 8'h3C, 1'b1}) begin errors++;
         $display("FAIL framing_err: got %b/%h/%b expected 1/3c/1", rx_valid, rx_data, frame_err); end
      pulse_ready();
      wait_clks(3 * 11 * 64);
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL framing_break: got %b expected 0", rx_valid); end
      rx = 1'b1;
      wait_clks(80);
   endtask

   task automatic test_overrun();
      int ov0 = overrun_cnt;
      rx_ready = 1'b0;
      send_frame(8'h11, 1'b1, good_par(8'h11));
      send_frame(8'h22, 1'b1, good_par(8'h22));
      wait_clks(3);
      checks++; if ({rx_valid, rx_data} !== {1'b1, 8'h11}) begin errors++;
         $display("FAIL overrun_keep: got %b/%h expected 1/11", rx_valid, rx_data); end
      checks++; if (overrun_cnt - ov0 != 1) begin errors++;
         $display("FAIL overrun_pulse: got %0d expected 1", overrun_cnt - ov0); end
      pulse_ready();
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL overrun_accept: got %b expected 0", rx_valid); end
   endtask

   task automatic test_parity();
      frame_t e;
      for (int p = 0; p < 2; p++) begin
         e = model(8'h07, 1'b1, p[0]);
         send_frame(8'h07, 1'b1, p[0]);
         wait_clks(3);
         checks++; if ({rx_valid, rx_data, frame_err, parity_err} !== {1'b1, e}) begin errors++;
            $display("FAIL parity_bit%0d: got %b/%h/%b/%b expected 1/%h/%b/%b", p,
                     rx_valid, rx_data, frame_err, parity_err, e.data, e.fe, e.pe); end
         pulse_ready();
      end
   endtask

   task automatic test_reset_mid_frame();
      send_frame(8'h99, 1'b1, good_par(8'h99));  // leave a frame in the buffer
      wait_clks(3);
      checks++; if ({rx_valid, rx_data} !== {1'b1, 8'h99}) begin errors++;
         $display("FAIL rstmid_pre: got %b/%h expected 1/99", rx_valid, rx_data); end
      drive_bit(1'b0);
      drive_bit(1'b0);
      drive_bit(1'b1);
      #(16 * baud_half);  // mid data bit 2
      reset_n = 1'b0;
      #1;
      checks++; if ({rx_valid, rx_data, frame_err, parity_err, overrun} !== 12'h000) begin errors++;
         $display("FAIL rstmid_outputs: got %b/%h/%b/%b/%b expected all 0",
                  rx_valid, rx_data, frame_err, parity_err, overrun); end
      rx = 1'b1;
      wait_clks(5);
      reset_n = 1'b1;
      wait_clks(5);
      send_frame(8'h5A, 1'b1, good_par(8'h5A));
      wait_clks(3);
      checks++; if ({rx_valid, rx_data, frame_err, parity_err} !== {1'b1, 8'h5A, 2'b00}) begin errors++;
         $display("FAIL rstmid_after: got %b/%h/%b/%b expected 1/5a/0/0", rx_valid, rx_data, frame_err, parity_err); end
      pulse_ready();
   endtask

   task automatic test_back_to_back();
      logic [7:0] d;
      logic       stop_bit;
      logic       pbit;
      int         ov0 = overrun_cnt;
      int         n;
      got_q.delete();
      exp_q.delete();
      rx_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         d        = 8'($urandom);
         stop_bit = ($urandom_range(0, 3) != 0);
         pbit     = 1'($urandom_range(0, 1));
         send_frame(d, stop_bit, pbit);
         exp_q.push_back(model(d, stop_bit, pbit));
         // A low stop bit needs idle time before the next start edge exists.
         if (!stop_bit || $urandom_range(0, 1) == 1) drive_bit(1'b1);
      end
      rx = 1'b1;
      wait_clks(10);
      rx_ready = 1'b0;
      checks++; if (got_q.size() != exp_q.size()) begin errors++;
         $display("FAIL b2b_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
      checks++; if (overrun_cnt != ov0) begin errors++;
         $display("FAIL b2b_overrun: got %0d expected 0", overrun_cnt - ov0); end
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin errors++;
            $display("FAIL b2b_frame%0d: got %h/%b/%b expected %h/%b/%b", i,
                     got_q[i].data, got_q[i].fe, got_q[i].pe, exp_q[i].data, exp_q[i].fe, exp_q[i].pe); end
      end
   endtask

   initial begin
      test_reset();
      test_clean_frame();
      test_glitch();
      test_framing();
      test_overrun();
      if (PAR_EN) test_parity();
      test_reset_mid_frame();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx16.md
# uart_rx16

Oversampling UART receiver that consumes the 16x baud clock from the baud generator and recovers serial frames from the `rx` line. It detects and validates start bits, samples each bit at mid-period, checks the stop bit (and optionally parity), and presents each byte on a one-entry valid/ready output buffer. It sits between the baud generator and the byte-consuming logic (FIFO or command decoder).

## Interface
- `DATA_BITS`, default 8: data bits per frame, sent LSB first. Legal range is 5 to 9.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd. Only used when parity is compiled in.
- `clk`  in  1: system clock; the only clock in the block.
- `reset_n`  in  1: asynchronous, active-low reset.
- `baud_clk16`  in  1: 16x baud square wave from the baud generator, sampled in the `clk` domain.
- `rx`  in  1: serial line; idle high; asynchronous to `clk`.
- `rx_data`  out  DATA_BITS: received word.
- `rx_valid`  out  1: `rx_data` and the error flags hold a frame.
- `rx_ready`  in  1: consumer accepts the frame when `rx_valid && rx_ready`.
- `frame_err`  out  1: stop bit was sampled as 0. Qualified by `rx_valid`.
- `parity_err`  out  1: parity mismatch. Qualified by `rx_valid`.
- `overrun`  out  1: one-cycle pulse; a completed frame was dropped.

## Operation
- **Tick generation:**
  - `tick` = rising edge of `baud_clk16`, formed from the current value and a registered copy.
  - `tick` is a single-`clk` pulse.
  - All bit timing counts ticks, never `clk` cycles.
- **Line synchronizer:** `rx` passes through 2 flops that reset to 1, giving `rx_s`. A falling edge is `rx_s` == 0 with the previous `rx_s` == 1.
- **FSM states:** IDLE, START, DATA, PARITY, STOP. It uses a 4-bit tick counter `cnt` and a bit index.
- **IDLE:** on a falling edge of `rx_s`, go to START with `cnt` = 0.
- **START:**
  - On the tick where `cnt` == 7 (mid start bit), check `rx_s`.
  - If `rx_s` == 0: go to DATA with `cnt` = 0 and bit index 0.
  - If `rx_s` == 1: the start was a glitch; return to IDLE with no output.
- **DATA:**
  - On the tick where `cnt` == 15, shift `rx_s` into the MSB of the shift register (LSB-first reception).
  - After `DATA_BITS` samples, go to PARITY if parity is compiled in, else STOP.
- **PARITY:** sample on the `cnt` == 15 tick, then go to STOP.
- **STOP:**
  - Sample on the `cnt` == 15 tick.
  - Set `frame_err` = ~`rx_s`.
  - Complete the frame and return to IDLE immediately, at mid stop bit, to resync on the next start.
- **Line held low:** a line held low (break) cannot retrigger, because IDLE requires a falling edge.
- **Frame completion into the output buffer:**
  - Buffer empty, or the consumer accepts in the same cycle: load `rx_data` and both error flags, and set `rx_valid` = 1.
  - Buffer full and no accept: drop the new frame, keep the old contents, and pulse `overrun`.
  - `rx_valid` clears on accept unless a new frame loads in the same cycle.
- **Reset mid-frame:** the FSM returns to IDLE and the partial frame is discarded.

## Timing
- **Reset values:**
  - `rx_data` = 0, `rx_valid` = 0, `frame_err` = 0, `parity_err` = 0, `overrun` = 0.
  - Synchronizer flops = 1; `baud_clk16` edge register = 0; FSM = IDLE.
- **Latency:**
  - `rx` edge to `rx_s` edge: 2 `clk`.
  - Start detection to START entry: 1 `clk`.
  - `rx_valid` rises 1 `clk` after the tick that samples the stop bit.
- **Handshake:** `rx_data` and the flags are stable while `rx_valid` is high and not accepted. The consumer may hold `rx_ready` high permanently.
- **Tolerance:** sampling at ticks 7/15 tolerates about ±3% baud mismatch over a 10-bit frame.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- **Defined:** the PARITY state exists and one parity bit is expected after data. `parity_err` = XOR of the data bits and the parity bit, XORed with `PARITY_ODD` (nonzero means mismatch).
- **Undefined:** there is no PARITY state, the frame is start + `DATA_BITS` + stop, and `parity_err` is tied to 0.

## Structure
- **Package `uart_pkg`:** holds
  - the `uart_rx_state_t` enum;
  - `OVERSAMPLE` = 16;
  - `MID_SAMPLE` = 7;
  - `LAST_SAMPLE` = 15.
- **Sub-module `uart_rx_sync`:** covers the 2-flop `rx` synchronizer, the falling-edge detect and the `baud_clk16` rising-edge tick. Its outputs are `rx_s`, `rx_fall` and `tick`.

## Test plan
- **Clean frame:** CLK_FREQ 50 MHz and BAUD_RATE 115200 on the driving baud generator; send frame 0xA5 with a good stop bit -> `rx_data` = 0xA5, `rx_valid` = 1, `frame_err` = 0, `parity_err` = 0; held until `rx_ready` is pulsed.
- **Glitch start:** `rx` low for 4 ticks, then high -> no `rx_valid`; FSM back in IDLE; the next 0x3C frame is received correctly.
- **Framing error:** 0x3C with stop bit = 0 -> `rx_data` = 0x3C, `frame_err` = 1; the line held low afterwards produces no further frames.
- **Overrun:** `rx_ready` = 0; send 0x11 then 0x22 -> `rx_data` stays 0x11, one `overrun` pulse. Then `rx_ready` = 1 for 1 cycle -> `rx_valid` = 0.
- **Parity (`UART_RX_PARITY_EN`, `PARITY_ODD` = 0):** 0x07 with parity bit 0 -> `parity_err` = 1; with parity bit 1 -> `parity_err` = 0.
- **Reset mid-frame:** assert `reset_n` low mid-DATA -> all outputs 0 immediately; after release, 0x5A is received correctly.
